// File: rtl/pre_if_stage_pkg.sv
// Shared types, widths and helpers for the pre-IF fetch stage.
// The state encodings are fixed 2-bit values so that waveforms and
// any external decoders see a stable numbering.
package pre_if_stage_pkg;

    // Width of {br_taken, br_target[31:0]} coming from ID.
    localparam int BR_BUS_WD        = 33;
    // Width of {adef, pc[31:0]} handed to IF.
    localparam int PFS_TO_FS_BUS_WD = 33;

    // The instruction bus only ever moves whole 32-bit words.
    localparam logic [1:0]  SRAM_SIZE_WORD = 2'd2;
    // One instruction is 4 bytes.
    localparam logic [31:0] PC_STEP        = 32'd4;

    // Fetch control states.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request the current pc
        S_HOLD  = 2'd1,  // address accepted, IF not ready to take it yet
        S_ADEF  = 2'd2,  // misaligned pc, offer ADEF without a bus request
        S_STALL = 2'd3   // ADEF handed over, park until a redirect
    } pfs_state_e;

    // Sequential successor of a pc; wraps modulo 2^32 with no trap.
    function automatic logic [31:0] pc_seq(input logic [31:0] pc);
        pc_seq = pc + PC_STEP;
    endfunction

    // A fetch address that is not word-aligned raises ADEF.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        pc_misaligned = (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// SRAM-like instruction fetch bus between the pre-IF stage (master)
// and the instruction memory side (slave).
interface pre_if_stage_if;

    logic        req;      // fetch request
    logic        wr;       // always 0: the fetch side never writes
    logic [1:0]  size;     // always a word
    logic [31:0] addr;     // fetch address
    logic        addr_ok;  // request accepted this cycle

    modport master (
        output req,
        output wr,
        output size,
        output addr,
        input  addr_ok
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  addr,
        output addr_ok
    );

endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch pc, issues instruction requests, resolves
// redirects (exception > ertn > branch > sequential) and hands each
// accepted fetch to IF over a valid/allowin handshake. A redirect that
// arrives while an accepted address is still parked tells IF to drop the
// response that address will produce.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fs_allowin,
    input  logic [BR_BUS_WD-1:0]          br_bus,
    input  logic [1:0]                    ws_to_fs_bus,
    input  logic [31:0]                   ex_entry,
    input  logic [31:0]                   ertn_entry,
    output logic                          to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0]   pfs_to_fs_bus,
    output logic                          pfs_discard,
    pre_if_stage_if.master                inst_sram
);

    // Registered state.
    pfs_state_e  state_r;
    logic [31:0] pc_r;

    // Next-state values.
    pfs_state_e  state_nxt_s;
    logic [31:0] pc_nxt_s;

    // Unpacked redirect inputs.
    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic        ws_ex_s;
    logic        ws_ertn_s;

    // Redirect resolution.
    logic        redir_s;
    logic [31:0] tgt_s;

    // Handshake terms.
    logic        req_s;
    logic        ready_s;
    logic        valid_s;
    logic        fire_s;
    logic        discard_s;
    logic        adef_s;

    assign br_taken_s  = br_bus[32];
    assign br_target_s = br_bus[31:0];
    assign ws_ertn_s   = ws_to_fs_bus[1];
    assign ws_ex_s     = ws_to_fs_bus[0];

    // Pick the redirect target: exception beats ertn beats branch.
    always_comb begin
        redir_s = ws_ex_s | ws_ertn_s | br_taken_s;
        if (ws_ex_s) begin
            tgt_s = ex_entry;
        end else if (ws_ertn_s) begin
            tgt_s = ertn_entry;
        end else begin
            tgt_s = br_target_s;
        end
    end

    // Handshake and bus-facing terms; everything is quiet while reset is held.
    always_comb begin
        req_s     = 1'b0;
        ready_s   = 1'b0;
        valid_s   = 1'b0;
        fire_s    = 1'b0;
        discard_s = 1'b0;
        adef_s    = 1'b0;
        if (!reset) begin
            // A redirect cycle never issues a request: the pc is about to change.
            req_s = (state_r == S_REQ) && !redir_s;
            case (state_r)
                S_REQ:   ready_s = inst_sram.addr_ok;
                S_HOLD:  ready_s = 1'b1;
                S_ADEF:  ready_s = 1'b1;
                S_STALL: ready_s = 1'b0;
                default: ready_s = 1'b0;
            endcase
            valid_s   = ready_s && !redir_s;
            fire_s    = valid_s && fs_allowin;
            // Only a parked, already-accepted address has a response on its way.
            discard_s = redir_s && (state_r == S_HOLD);
            adef_s    = (state_r == S_ADEF) && pc_misaligned(pc_r);
        end else begin
            req_s     = 1'b0;
            ready_s   = 1'b0;
            valid_s   = 1'b0;
            fire_s    = 1'b0;
            discard_s = 1'b0;
            adef_s    = 1'b0;
        end
    end

    // Next pc and state; a redirect overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (redir_s) begin
            pc_nxt_s    = tgt_s;
            state_nxt_s = pc_misaligned(tgt_s) ? S_ADEF : S_REQ;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (inst_sram.addr_ok) begin
                        if (fire_s) begin
                            // Zero-bubble steady state: request the next word straight away.
                            pc_nxt_s    = pc_seq(pc_r);
                            state_nxt_s = S_REQ;
                        end else begin
                            state_nxt_s = S_HOLD;
                        end
                    end else begin
                        state_nxt_s = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (fire_s) begin
                        pc_nxt_s    = pc_seq(pc_r);
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end
                S_ADEF: begin
                    if (fire_s) begin
                        state_nxt_s = S_STALL;
                    end else begin
                        state_nxt_s = S_ADEF;
                    end
                end
                S_STALL: begin
                    state_nxt_s = S_STALL;
                end
                default: begin
                    state_nxt_s = S_REQ;
                end
            endcase
        end
    end

    // pc and state registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            state_r <= S_REQ;
        end else begin
            pc_r    <= pc_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign inst_sram.req  = req_s;
    assign inst_sram.wr   = 1'b0;
    assign inst_sram.size = SRAM_SIZE_WORD;
    assign inst_sram.addr = pc_r;

    assign to_fs_valid   = valid_s;
    assign pfs_discard   = discard_s;
    assign pfs_to_fs_bus = reset ? {PFS_TO_FS_BUS_WD{1'b0}} : {adef_s, pc_r};

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: sequential fetch, hold on !allowin,
// redirect with discard, redirect priority, ADEF/stall, pc wrap and
// asynchronous reset mid-hold. Inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_pre_if_stage;
    import pre_if_stage_pkg::*;

    logic                        clk;
    logic                        reset;
    logic                        fs_allowin;
    logic [BR_BUS_WD-1:0]        br_bus;
    logic [1:0]                  ws_to_fs_bus;
    logic [31:0]                 ex_entry;
    logic [31:0]                 ertn_entry;
    logic                        to_fs_valid;
    logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus;
    logic                        pfs_discard;

    int tests_run;
    int tests_failed;

    pre_if_stage_if inst_sram ();

    pre_if_stage #(.RESET_PC(32'h1c000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .fs_allowin    (fs_allowin),
        .br_bus        (br_bus),
        .ws_to_fs_bus  (ws_to_fs_bus),
        .ex_entry      (ex_entry),
        .ertn_entry    (ertn_entry),
        .to_fs_valid   (to_fs_valid),
        .pfs_to_fs_bus (pfs_to_fs_bus),
        .pfs_discard   (pfs_discard),
        .inst_sram     (inst_sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr, input logic req, input logic valid);
        check({tag, ".addr"},  {32'd0, inst_sram.addr}, {32'd0, addr});
        check({tag, ".req"},   {63'd0, inst_sram.req},  {63'd0, req});
        check({tag, ".valid"}, {63'd0, to_fs_valid},    {63'd0, valid});
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        fs_allowin        = 1'b0;
        br_bus            = 33'd0;
        ws_to_fs_bus      = 2'b00;
        ex_entry          = 32'd0;
        ertn_entry        = 32'd0;
        inst_sram.addr_ok = 1'b0;

        // Reset values.
        #1;
        check("rst.req",     {63'd0, inst_sram.req},  64'd0);
        check("rst.wr",      {63'd0, inst_sram.wr},   64'd0);
        check("rst.size",    {62'd0, inst_sram.size}, 64'd2);
        check("rst.addr",    {32'd0, inst_sram.addr}, 64'h1c000000);
        check("rst.valid",   {63'd0, to_fs_valid},    64'd0);
        check("rst.discard", {63'd0, pfs_discard},    64'd0);
        check("rst.bus",     {31'd0, pfs_to_fs_bus},  64'd0);

        // 1. Sequential fetch, one per cycle.
        @(negedge clk);
        @(negedge clk);
        reset             = 1'b0;
        fs_allowin        = 1'b1;
        inst_sram.addr_ok = 1'b1;
        #1;
        check_fetch("seq0", 32'h1c000000, 1'b1, 1'b1);
        check("seq0.bus", {31'd0, pfs_to_fs_bus}, {31'd0, 1'b0, 32'h1c000000});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            check_fetch("seq", 32'h1c000000 + 32'(4 * k), 1'b1, 1'b1);
        end

        // 2. Hold at 1c000010 while IF is busy.
        @(negedge clk);
        fs_allowin = 1'b0;
        #1;
        check_fetch("hold_acc", 32'h1c000010, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check_fetch("hold", 32'h1c000010, 1'b0, 1'b1);
        end
        @(negedge clk);
        fs_allowin = 1'b1;
        #1;
        check_fetch("hold_fire", 32'h1c000010, 1'b0, 1'b1);
        @(negedge clk); #1;
        check_fetch("after_hold", 32'h1c000014, 1'b1, 1'b1);

        // 3. Branch while holding at 1c000020 -> discard.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        fs_allowin = 1'b0;
        #1;
        check_fetch("pre_br", 32'h1c000020, 1'b1, 1'b1);
        @(negedge clk);
        br_bus = {1'b1, 32'h1c000100};
        #1;
        check("br.discard", {63'd0, pfs_discard}, 64'd1);
        check_fetch("br", 32'h1c000020, 1'b0, 1'b0);
        @(negedge clk);
        br_bus     = 33'd0;
        fs_allowin = 1'b1;
        #1;
        check_fetch("br_tgt", 32'h1c000100, 1'b1, 1'b1);
        check("br_tgt.discard", {63'd0, pfs_discard}, 64'd0);

        // 4. Exception beats ertn beats branch.
        @(negedge clk);
        ex_entry     = 32'h1c008000;
        ertn_entry   = 32'h1c004000;
        ws_to_fs_bus = 2'b11;
        br_bus       = {1'b1, 32'h1c000200};
        #1;
        check_fetch("prio", 32'h1c000104, 1'b0, 1'b0);
        check("prio.discard", {63'd0, pfs_discard}, 64'd0);
        @(negedge clk);
        ws_to_fs_bus = 2'b00;
        br_bus       = 33'd0;
        #1;
        check_fetch("ex_tgt", 32'h1c008000, 1'b1, 1'b1);
        @(negedge clk);
        ws_to_fs_bus = 2'b10;
        br_bus       = {1'b1, 32'h1c000200};
        #1;
        check("ertn.req", {63'd0, inst_sram.req}, 64'd0);
        @(negedge clk);
        ws_to_fs_bus = 2'b00;
        br_bus       = 33'd0;
        #1;
        check_fetch("ertn_tgt", 32'h1c004000, 1'b1, 1'b1);

        // 5. Misaligned branch -> ADEF, stall, exception resumes.
        @(negedge clk);
        br_bus = {1'b1, 32'h1c000102};
        #1;
        @(negedge clk);
        br_bus     = 33'd0;
        fs_allowin = 1'b0;
        #1;
        check_fetch("adef", 32'h1c000102, 1'b0, 1'b1);
        check("adef.bus", {31'd0, pfs_to_fs_bus}, {31'd0, 1'b1, 32'h1c000102});
        @(negedge clk);
        fs_allowin = 1'b1;
        #1;
        check_fetch("adef_fire", 32'h1c000102, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check_fetch("stall", 32'h1c000102, 1'b0, 1'b0);
        end
        @(negedge clk);
        ws_to_fs_bus = 2'b01;
        ex_entry     = 32'h1c008000;
        #1;
        check("stall_ex.discard", {63'd0, pfs_discard}, 64'd0);
        @(negedge clk);
        ws_to_fs_bus = 2'b00;
        #1;
        check_fetch("resume", 32'h1c008000, 1'b1, 1'b1);

        // pc wraps from fffffffc to 0.
        @(negedge clk);
        ex_entry     = 32'hfffffffc;
        ws_to_fs_bus = 2'b01;
        #1;
        @(negedge clk);
        ws_to_fs_bus = 2'b00;
        #1;
        check_fetch("wrap_top", 32'hfffffffc, 1'b1, 1'b1);
        check("wrap_top.bus", {31'd0, pfs_to_fs_bus}, {31'd0, 1'b0, 32'hfffffffc});
        @(negedge clk); #1;
        check_fetch("wrap_zero", 32'h00000000, 1'b1, 1'b1);

        // 6. Asynchronous reset pulse while holding.
        @(negedge clk);
        fs_allowin = 1'b0;
        #1;
        check_fetch("pre_rst", 32'h00000004, 1'b1, 1'b1);
        @(negedge clk); #1;
        check_fetch("rst_hold", 32'h00000004, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check_fetch("arst", 32'h1c000000, 1'b0, 1'b0);
        check("arst.bus", {31'd0, pfs_to_fs_bus}, 64'd0);
        #1;
        reset             = 1'b0;
        inst_sram.addr_ok = 1'b0;
        @(negedge clk);
        inst_sram.addr_ok = 1'b1;
        fs_allowin        = 1'b1;
        #1;
        check_fetch("restart", 32'h1c000000, 1'b1, 1'b1);
        @(negedge clk); #1;
        check_fetch("restart1", 32'h1c000004, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
